// File: rtl/burst_capture_sequencer_pkg.sv
// Shared types and constants for the burst capture sequencer: state encoding,
// default settings-bus addresses and counter widths.
package burst_capture_sequencer_pkg;

  localparam int unsigned SR_AW     = 8;
  localparam int unsigned SR_DW     = 32;
  localparam int unsigned CFG_W     = 16;
  localparam int unsigned CNT_W     = 16;
  localparam int unsigned PENDING_W = 4;

  localparam logic [SR_AW-1:0] SR_BURST_LEN_DEF = 8'd6;
  localparam logic [SR_AW-1:0] SR_HOLDOFF_DEF   = 8'd7;
  localparam logic [SR_AW-1:0] SR_ENABLE_DEF    = 8'd8;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_PHASE = 2'd1,
    S_PASS       = 2'd2,
    S_HOLDOFF    = 2'd3
  } state_t;

  // Saturating increment for the status counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/burst_capture_sequencer_if.sv
// Stream bundle between detector, phase source and the burst capture sequencer.
// The slave modport is the sequencer's view; master is the surrounding fabric.
interface burst_capture_sequencer_if #(
  parameter int unsigned WIDTH_SAMPLE = 16,
  parameter int unsigned WIDTH_PHASE  = 32
);

  logic [2*WIDTH_SAMPLE-1:0] i_tdata;
  logic                      i_tlast;
  logic                      i_tvalid;
  logic                      i_tready;
  logic [WIDTH_PHASE-1:0]    phase_tdata;
  logic                      phase_tvalid;
  logic                      phase_tready;
  logic [2*WIDTH_SAMPLE-1:0] o_tdata;
  logic [WIDTH_PHASE-1:0]    o_tuser;
  logic                      o_tlast;
  logic                      o_tvalid;
  logic                      o_tready;

  modport slave (
    input  i_tdata, i_tlast, i_tvalid,
    output i_tready,
    input  phase_tdata, phase_tvalid,
    output phase_tready,
    output o_tdata, o_tuser, o_tlast, o_tvalid,
    input  o_tready
  );

  modport master (
    output i_tdata, i_tlast, i_tvalid,
    input  i_tready,
    output phase_tdata, phase_tvalid,
    input  phase_tready,
    input  o_tdata, o_tuser, o_tlast, o_tvalid,
    output o_tready
  );

endinterface

// File: rtl/axi_fifo_flop.sv
// One-entry registered stream stage; accepts a new beat whenever it is empty
// or its current beat is leaving in the same cycle.
module axi_fifo_flop #(
  parameter int unsigned WIDTH = 65
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tvalid,
  output logic             o_in_ready_c,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tvalid,
  input  logic             i_out_ready
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  assign o_in_ready_c = !r_valid || i_out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (o_in_ready_c) begin
      r_valid <= i_tvalid;
      if (i_tvalid) begin
        r_data <= i_tdata;
      end
    end
  end

  assign o_tdata  = r_data;
  assign o_tvalid = r_valid;

endmodule

// File: rtl/burst_capture_fsm.sv
// Burst sequencing core: trigger/phase pairing, burst and holdoff counting,
// ignored-trigger bookkeeping and draining of orphaned phase words.
module burst_capture_fsm
  import burst_capture_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH_PHASE = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_enable,
  input  logic [CFG_W-1:0]       i_burst_len,
  input  logic [CFG_W-1:0]       i_holdoff,
  input  logic                   i_in_valid,
  input  logic                   i_in_last,
  input  logic [WIDTH_PHASE-1:0] i_phase_data,
  input  logic                   i_phase_valid,
  input  logic                   i_out_ready,
  output logic                   o_in_ready_c,
  output logic                   o_phase_ready_c,
  output logic                   o_fwd_valid_c,
  output logic                   o_fwd_last_c,
  output logic [WIDTH_PHASE-1:0] o_phase,
  output logic [CNT_W-1:0]       o_burst_count,
  output logic [CNT_W-1:0]       o_missed_count
);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CFG_W-1:0]       r_cnt;
  logic [PENDING_W-1:0]   r_pending;
  logic [WIDTH_PHASE-1:0] r_phase;
  logic [CNT_W-1:0]       r_burst_count;
  logic [CNT_W-1:0]       r_missed_count;

  logic w_load_phase;
  logic w_load_hold;
  logic w_cnt_dec;
  logic w_done;
  logic w_ignore;
  logic w_miss;
  logic w_drain;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    o_in_ready_c    = 1'b0;
    o_phase_ready_c = (r_pending != '0);
    o_fwd_valid_c   = 1'b0;
    o_fwd_last_c    = 1'b0;
    w_load_phase    = 1'b0;
    w_load_hold     = 1'b0;
    w_cnt_dec       = 1'b0;
    w_done          = 1'b0;
    w_ignore        = 1'b0;
    w_miss          = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_in_ready_c = 1'b1;
        if (i_in_valid && i_in_last) begin
          if (i_enable) begin
            w_state_nxt = S_WAIT_PHASE;
          end else begin
            w_ignore = 1'b1;
          end
        end
      end
      S_WAIT_PHASE: begin
        o_phase_ready_c = 1'b1;
        if (i_phase_valid) begin
          w_load_phase = 1'b1;
          w_state_nxt  = S_PASS;
        end
      end
      S_PASS: begin
        // Input pacing follows the output flop so no beat is dropped under stall.
        o_in_ready_c  = i_out_ready;
        o_fwd_valid_c = i_in_valid;
        o_fwd_last_c  = (r_cnt == CFG_W'(1));
        if (i_in_valid && i_out_ready) begin
          w_cnt_dec = 1'b1;
          w_ignore  = i_in_last;
          w_miss    = i_in_last;
          if (r_cnt == CFG_W'(1)) begin
            w_done = 1'b1;
            if (i_holdoff == '0) begin
              w_state_nxt = S_IDLE;
            end else begin
              w_load_hold = 1'b1;
              w_state_nxt = S_HOLDOFF;
            end
          end
        end
      end
      S_HOLDOFF: begin
        o_in_ready_c = 1'b1;
        if (i_in_valid) begin
          w_cnt_dec = 1'b1;
          w_ignore  = i_in_last;
          w_miss    = i_in_last;
          if (r_cnt == CFG_W'(1)) begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_drain = i_phase_valid && o_phase_ready_c && (r_state != S_WAIT_PHASE);

  // Working counters, latched phase and status counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt          <= '0;
      r_pending      <= '0;
      r_phase        <= '0;
      r_burst_count  <= '0;
      r_missed_count <= '0;
    end else begin
      if (w_load_phase) begin
        r_phase <= i_phase_data;
        r_cnt   <= (i_burst_len == '0) ? CFG_W'(1) : i_burst_len;
      end else if (w_load_hold) begin
        r_cnt <= i_holdoff;
      end else if (w_cnt_dec) begin
        r_cnt <= r_cnt - CFG_W'(1);
      end
      if (w_done) begin
        r_burst_count <= r_burst_count + CNT_W'(1);
      end
      if (w_miss) begin
        r_missed_count <= sat_inc(r_missed_count);
      end
      case ({w_ignore, w_drain})
        2'b10: begin
          if (r_pending != '1) begin
            r_pending <= r_pending + PENDING_W'(1);
          end
        end
        2'b01:   r_pending <= r_pending - PENDING_W'(1);
        default: r_pending <= r_pending;
      endcase
    end
  end

  assign o_phase        = r_phase;
  assign o_burst_count  = r_burst_count;
  assign o_missed_count = r_missed_count;

endmodule

// File: rtl/setting_reg.sv
// Single settings-bus register: loads on strobe with a matching address.
module setting_reg
  import burst_capture_sequencer_pkg::*;
#(
  parameter int unsigned       WIDTH    = 16,
  parameter logic [SR_AW-1:0]  MY_ADDR  = '0,
  parameter logic [WIDTH-1:0]  AT_RESET = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_stb,
  input  logic [SR_AW-1:0] i_addr,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_out
);

  logic [WIDTH-1:0] r_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out <= AT_RESET;
    end else if (i_stb && (i_addr == MY_ADDR)) begin
      r_out <= i_data;
    end
  end

  assign o_out = r_out;

endmodule

// File: rtl/burst_capture_sequencer.sv
// Cuts the plateau-detector sample stream into phase-tagged capture bursts;
// wires the settings registers, the sequencing core and the output flop.
module burst_capture_sequencer
  import burst_capture_sequencer_pkg::*;
#(
  parameter int unsigned      WIDTH_SAMPLE = 16,
  parameter int unsigned      WIDTH_PHASE  = 32,
  parameter logic [SR_AW-1:0] SR_BURST_LEN = SR_BURST_LEN_DEF,
  parameter logic [SR_AW-1:0] SR_HOLDOFF   = SR_HOLDOFF_DEF,
  parameter logic [SR_AW-1:0] SR_ENABLE    = SR_ENABLE_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     set_stb,
  input  logic [SR_AW-1:0]         set_addr,
  input  logic [SR_DW-1:0]         set_data,
  burst_capture_sequencer_if.slave bus,
  output logic [CNT_W-1:0]         burst_count,
  output logic [CNT_W-1:0]         missed_count
);

  localparam int unsigned W_IQ   = 2 * WIDTH_SAMPLE;
  localparam int unsigned W_BEAT = W_IQ + WIDTH_PHASE + 1;

  logic [CFG_W-1:0]       w_burst_len;
  logic [CFG_W-1:0]       w_holdoff;
  logic                   w_enable;
  logic                   w_flop_ready;
  logic                   w_fwd_valid;
  logic                   w_fwd_last;
  logic [WIDTH_PHASE-1:0] w_phase;
  logic [W_BEAT-1:0]      w_flop_in;
  logic [W_BEAT-1:0]      w_flop_out;
  logic                   w_unused_ok;

  assign w_unused_ok = &{1'b0, set_data[SR_DW-1:CFG_W]};

  setting_reg #(.WIDTH(CFG_W), .MY_ADDR(SR_BURST_LEN), .AT_RESET(CFG_W'(1))) u_sr_len (
    .clk    (clk),
    .reset  (reset),
    .i_stb  (set_stb),
    .i_addr (set_addr),
    .i_data (set_data[CFG_W-1:0]),
    .o_out  (w_burst_len)
  );

  setting_reg #(.WIDTH(CFG_W), .MY_ADDR(SR_HOLDOFF), .AT_RESET(CFG_W'(0))) u_sr_hold (
    .clk    (clk),
    .reset  (reset),
    .i_stb  (set_stb),
    .i_addr (set_addr),
    .i_data (set_data[CFG_W-1:0]),
    .o_out  (w_holdoff)
  );

  setting_reg #(.WIDTH(1), .MY_ADDR(SR_ENABLE), .AT_RESET(1'b0)) u_sr_en (
    .clk    (clk),
    .reset  (reset),
    .i_stb  (set_stb),
    .i_addr (set_addr),
    .i_data (set_data[0:0]),
    .o_out  (w_enable)
  );

  burst_capture_fsm #(.WIDTH_PHASE(WIDTH_PHASE)) u_fsm (
    .clk             (clk),
    .reset           (reset),
    .i_enable        (w_enable),
    .i_burst_len     (w_burst_len),
    .i_holdoff       (w_holdoff),
    .i_in_valid      (bus.i_tvalid),
    .i_in_last       (bus.i_tlast),
    .i_phase_data    (bus.phase_tdata),
    .i_phase_valid   (bus.phase_tvalid),
    .i_out_ready     (w_flop_ready),
    .o_in_ready_c    (bus.i_tready),
    .o_phase_ready_c (bus.phase_tready),
    .o_fwd_valid_c   (w_fwd_valid),
    .o_fwd_last_c    (w_fwd_last),
    .o_phase         (w_phase),
    .o_burst_count   (burst_count),
    .o_missed_count  (missed_count)
  );

  assign w_flop_in = {w_fwd_last, w_phase, bus.i_tdata};

  axi_fifo_flop #(.WIDTH(W_BEAT)) u_out_flop (
    .clk          (clk),
    .reset        (reset),
    .i_tdata      (w_flop_in),
    .i_tvalid     (w_fwd_valid),
    .o_in_ready_c (w_flop_ready),
    .o_tdata      (w_flop_out),
    .o_tvalid     (bus.o_tvalid),
    .i_out_ready  (bus.o_tready)
  );

  assign bus.o_tdata = w_flop_out[W_IQ-1:0];
  assign bus.o_tuser = w_flop_out[W_IQ +: WIDTH_PHASE];
  assign bus.o_tlast = w_flop_out[W_BEAT-1];

endmodule

// File: tb/tb_burst_capture_sequencer.sv
// Directed bench for burst_capture_sequencer: vector table of single bursts
// plus hand-built holdoff, backpressure, disable and reset sequences.
module tb_burst_capture_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic [15:0] burst_count;
  logic [15:0] missed_count;

  int   total = 0;
  int   bad = 0;
  int   timeouts = 0;
  int   exp_bursts = 0;
  int   exp_missed = 0;
  int   cyc = 0;
  logic bp_en = 1'b0;

  typedef logic [64:0] beat_t;
  beat_t q[$];
  logic  stalled = 1'b0;
  beat_t stall_beat;

  typedef struct {
    logic [15:0] len;
    logic [15:0] hold;
    int          n;
    int          trig;
    logic [31:0] ph;
    int          exp_n;
    int          exp_first;
  } vec_t;
  vec_t vecs[5];

  always #5 clk = ~clk;

  burst_capture_sequencer_if bus ();

  burst_capture_sequencer u_dut (
    .clk          (clk),
    .reset        (reset),
    .set_stb      (set_stb),
    .set_addr     (set_addr),
    .set_data     (set_data),
    .bus          (bus),
    .burst_count  (burst_count),
    .missed_count (missed_count)
  );

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic timed_out(input string nm);
    total++;
    bad++;
    timeouts++;
    $display("FAIL %s: handshake never completed", nm);
    if (timeouts > 3) begin
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  endtask

  // Output ready: held high, or high one cycle in three under backpressure.
  initial begin
    bus.o_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      bus.o_tready = bp_en ? ((cyc % 3) == 0) : 1'b1;
    end
  end

  // Output monitor: collects accepted beats and checks stability while stalled.
  always @(negedge clk) begin
    if (reset) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_hold", 128'({bus.o_tvalid, bus.o_tdata, bus.o_tuser, bus.o_tlast}),
              128'({1'b1, stall_beat}));
      end
      if (bus.o_tvalid && bus.o_tready) begin
        q.push_back({bus.o_tdata, bus.o_tuser, bus.o_tlast});
      end
      stalled    = bus.o_tvalid && !bus.o_tready;
      stall_beat = {bus.o_tdata, bus.o_tuser, bus.o_tlast};
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    set_addr = a;
    set_data = d;
    set_stb  = 1'b1;
    @(posedge clk);
    #1;
    set_stb  = 1'b0;
  endtask

  task automatic push(input logic [31:0] d, input logic last);
    int   n;
    logic acc;
    n = 0;
    bus.i_tdata  = d;
    bus.i_tlast  = last;
    bus.i_tvalid = 1'b1;
    forever begin
      @(negedge clk);
      acc = bus.i_tready;
      @(posedge clk);
      #1;
      if (acc) break;
      n++;
      if (n > 200) begin
        timed_out("push_timeout");
        break;
      end
    end
    bus.i_tvalid = 1'b0;
    bus.i_tlast  = 1'b0;
  endtask

  task automatic send_phase(input logic [31:0] p);
    int   n;
    logic acc;
    n = 0;
    bus.phase_tdata  = p;
    bus.phase_tvalid = 1'b1;
    forever begin
      @(negedge clk);
      acc = bus.phase_tready;
      @(posedge clk);
      #1;
      if (acc) break;
      n++;
      if (n > 200) begin
        timed_out("phase_timeout");
        break;
      end
    end
    bus.phase_tvalid = 1'b0;
  endtask

  // Samples 1..n tagged (tag<<16 | index); up to three triggers, each followed by its phase.
  task automatic stream(input int tag, input int n,
                        input int t0, input logic [31:0] p0,
                        input int t1, input logic [31:0] p1,
                        input int t2, input logic [31:0] p2);
    for (int i = 1; i <= n; i++) begin
      push(32'((tag << 16) | i), (i == t0) || (i == t1) || (i == t2));
      if (i == t0) send_phase(p0);
      if (i == t1) send_phase(p1);
      if (i == t2) send_phase(p2);
    end
  endtask

  task automatic drain();
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic check_burst(input string nm, input int base, input int avail, input int tag,
                             input int first, input int n, input logic [31:0] ph);
    check({nm, "_beats"}, 128'(avail), 128'(n));
    for (int j = 0; j < n; j++) begin
      if (base + j < q.size()) begin
        check(nm, 128'(q[base + j]),
              128'({32'((tag << 16) | (first + j)), ph, (j == n - 1)}));
      end
    end
  endtask

  initial begin
    int base;
    vecs[0] = '{16'd80, 16'd0,  100, 10, 32'h12345678, 80, 11};
    vecs[1] = '{16'd0,  16'd0,  5,   2,  32'hA5A50001, 1,  3};
    vecs[2] = '{16'd1,  16'd3,  8,   1,  32'h0BADF00D, 1,  2};
    vecs[3] = '{16'd3,  16'd2,  10,  4,  32'hCAFE0003, 3,  5};
    vecs[4] = '{16'd2,  16'd0,  6,   1,  32'hFFFF0004, 2,  2};

    reset            = 1'b1;
    set_stb          = 1'b0;
    set_addr         = '0;
    set_data         = '0;
    bus.i_tdata      = '0;
    bus.i_tlast      = 1'b0;
    bus.i_tvalid     = 1'b0;
    bus.phase_tdata  = '0;
    bus.phase_tvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    @(negedge clk);
    check("rst_tvalid", 128'(bus.o_tvalid), 128'(0));
    check("rst_tlast", 128'(bus.o_tlast), 128'(0));
    check("rst_tdata", 128'(bus.o_tdata), 128'(0));
    check("rst_tuser", 128'(bus.o_tuser), 128'(0));
    check("rst_bursts", 128'(burst_count), 128'(0));
    check("rst_missed", 128'(missed_count), 128'(0));
    check("rst_in_ready", 128'(bus.i_tready), 128'(1));
    check("rst_phase_ready", 128'(bus.phase_tready), 128'(0));
    @(posedge clk);
    #1;

    wr(8'd8, 32'd1);
    for (int v = 0; v < 5; v++) begin
      wr(8'd6, 32'(vecs[v].len));
      wr(8'd7, 32'(vecs[v].hold));
      base = q.size();
      stream(v + 1, vecs[v].n, vecs[v].trig, vecs[v].ph, 0, '0, 0, '0);
      drain();
      exp_bursts++;
      check_burst($sformatf("vec%0d", v), base, q.size() - base, v + 1,
                  vecs[v].exp_first, vecs[v].exp_n, vecs[v].ph);
      check($sformatf("vec%0d_bursts", v), 128'(burst_count), 128'(exp_bursts));
      check($sformatf("vec%0d_missed", v), 128'(missed_count), 128'(exp_missed));
    end

    // Second trigger lands 50 samples into a 100-sample holdoff; the third is clear of it.
    wr(8'd6, 32'd16);
    wr(8'd7, 32'd100);
    base = q.size();
    stream(10, 290, 1, 32'h11110001, 67, 32'h22220002, 167, 32'h33330003);
    drain();
    exp_bursts += 2;
    exp_missed += 1;
    check("hold_total_beats", 128'(q.size() - base), 128'(32));
    check_burst("hold_b1", base, 16, 10, 2, 16, 32'h11110001);
    check_burst("hold_b2", base + 16, q.size() - base - 16, 10, 168, 16, 32'h33330003);
    check("hold_missed", 128'(missed_count), 128'(exp_missed));
    check("hold_bursts", 128'(burst_count), 128'(exp_bursts));
    check("hold_pending_clear", 128'(bus.phase_tready), 128'(0));

    wr(8'd6, 32'd64);
    wr(8'd7, 32'd0);
    bp_en = 1'b1;
    base = q.size();
    stream(20, 70, 2, 32'h5555AAAA, 0, '0, 0, '0);
    repeat (20) @(posedge clk);
    #1;
    bp_en = 1'b0;
    drain();
    exp_bursts++;
    check_burst("bp", base, q.size() - base, 20, 3, 64, 32'h5555AAAA);
    check("bp_bursts", 128'(burst_count), 128'(exp_bursts));

    // Disarmed: trigger is discarded without a miss, its phase still drained.
    wr(8'd8, 32'd0);
    base = q.size();
    stream(30, 5, 2, 32'h0000BEEF, 0, '0, 0, '0);
    drain();
    check("en0_beats", 128'(q.size() - base), 128'(0));
    check("en0_missed", 128'(missed_count), 128'(exp_missed));
    check("en0_bursts", 128'(burst_count), 128'(exp_bursts));
    check("en0_pending_clear", 128'(bus.phase_tready), 128'(0));

    wr(8'd6, 32'd80);
    wr(8'd8, 32'd1);
    push(32'((40 << 16) | 1), 1'b1);
    send_phase(32'hDEAD0001);
    for (int i = 2; i <= 6; i++) push(32'((40 << 16) | i), 1'b0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_tvalid", 128'(bus.o_tvalid), 128'(0));
    check("mid_rst_tlast", 128'(bus.o_tlast), 128'(0));
    check("mid_rst_bursts", 128'(burst_count), 128'(0));
    check("mid_rst_missed", 128'(missed_count), 128'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_bursts = 0;
    exp_missed = 0;

    wr(8'd6, 32'd80);
    wr(8'd8, 32'd1);
    base = q.size();
    stream(41, 100, 10, 32'h0F0F0F0F, 0, '0, 0, '0);
    drain();
    exp_bursts++;
    check_burst("post_rst", base, q.size() - base, 41, 11, 80, 32'h0F0F0F0F);
    check("post_rst_bursts", 128'(burst_count), 128'(exp_bursts));
    check("post_rst_missed", 128'(missed_count), 128'(exp_missed));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
